mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 129 ++++++++++++
 tb/tb_mul_div_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide with HI/LO result registers; fixed 33-cycle latency from start to result.
// No backpressure: start, mthi and mtlo are dropped while busy; mthi/mtlo take priority over start in IDLE.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        launch, wr_res;
  logic        is_div, neg_q, neg_r, div_zero;
  logic [31:0] mc, acc_hi, acc_lo;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic        div_ok;
  logic [63:0] prod, prod_fix;
  logic [31:0] q_fix, r_fix, res_hi, res_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    wr_res    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !mthi && !mtlo) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 5'd31) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        wr_res    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Signed ops work on magnitudes; the sign is restored in FIX.
  assign a_mag = (op[0] && A[31]) ? (32'd0 - A) : A;
  assign b_mag = (op[0] && B[31]) ? (32'd0 - B) : B;

  // Multiply: acc_hi accumulates, acc_lo holds the multiplier and shifts in product bits.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mc} : 33'd0);

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_diff  = div_shift - {1'b0, mc};
  assign div_ok    = ~div_diff[32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 5'd0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      mc       <= 32'd0;
      acc_hi   <= 32'd0;
      acc_lo   <= 32'd0;
    end else if (launch) begin
      cnt      <= 5'd0;
      is_div   <= op[1];
      neg_q    <= op[0] & (A[31] ^ B[31]);
      neg_r    <= op[0] & A[31];
      div_zero <= op[1] & (B == 32'd0);
      acc_hi   <= 32'd0;
      mc       <= op[1] ? b_mag : a_mag;
      acc_lo   <= op[1] ? a_mag : b_mag;
    end else if (state == RUN) begin
      cnt <= cnt + 5'd1;
      if (is_div) begin
        acc_hi <= div_ok ? div_diff[31:0] : div_shift[31:0];
        acc_lo <= {acc_lo[30:0], div_ok};
      end else begin
        acc_hi <= mul_sum[32:1];
        acc_lo <= {mul_sum[0], acc_lo[31:1]};
      end
    end
  end

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? (64'd0 - prod) : prod;
  // Divide by zero leaves |A| as remainder, so only the quotient needs forcing.
  assign q_fix    = div_zero ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - acc_lo) : acc_lo);
  assign r_fix    = neg_r ? (32'd0 - acc_hi) : acc_hi;
  assign res_hi   = is_div ? r_fix : prod_fix[63:32];
  assign res_lo   = is_div ? q_fix : prod_fix[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI   <= 32'd0;
      LO   <= 32'd0;
      done <= 1'b0;
    end else begin
      done <= wr_res;
      if (wr_res) begin
        HI <= res_hi;
        LO <= res_lo;
      end else if (state == IDLE) begin
        if (mthi) HI <= A;
        if (mtlo) LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] pu;
    longint      ps;
    int          ia, ib;
    ia = a;
    ib = b;
    case (o)
      2'b00: begin pu = {32'd0, a} * {32'd0, b}; hi = pu[63:32]; lo = pu[31:0]; end
      2'b01: begin ps = longint'(ia) * longint'(ib); pu = ps; hi = pu[63:32]; lo = pu[31:0]; end
      2'b10: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 32'd0; end
        else begin lo = ia / ib; hi = ia % ib; end
      end
    endcase
  endtask

  // Launch one op, optionally poke start/mthi/mtlo mid-flight, and check timing and result.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit interfere);
    logic [31:0] eh, el;
    int bc, dc, done_at;
    ref_model(o, a, b, eh, el);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
    bc = 0; dc = 0; done_at = 0;
    for (int k = 1; k <= 36; k++) begin
      if (busy) bc++;
      if (done) begin dc++; done_at = k; end
      if (k == 34) begin
        checks++;
        if (HI !== eh) begin errors++; $display("FAIL %s HI: got %h expected %h", name, HI, eh); end
        checks++;
        if (LO !== el) begin errors++; $display("FAIL %s LO: got %h expected %h", name, LO, el); end
      end
      if (interfere && k == 5) begin start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = ~o; end
      if (interfere && k == 6) begin start = 1'b0; mthi = 1'b0; mtlo = 1'b0; end
      @(negedge clk);
    end
    checks++;
    if (bc != 33) begin errors++; $display("FAIL %s busy_cycles: got %0d expected 33", name, bc); end
    checks++;
    if (dc != 1 || done_at != 34) begin
      errors++; $display("FAIL %s done_pulse: got %0d pulses at cycle %0d expected 1 at 34", name, dc, done_at);
    end
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic test_reset;
    checks++;
    if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_state: got HI=%h LO=%h busy=%b done=%b expected all zero", HI, LO, busy, done);
    end
  endtask

  task automatic test_directed;
    run_op("mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div_neg7by2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_by0", 2'b10, 32'd100, 32'd0, 1'b0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("div_neg_by0", 2'b11, 32'h8000_0005, 32'd0, 1'b0);
    run_op("mult_minint", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_op("random", 2'($urandom), a, b, 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    run_op("busy_ignore", 2'b10, 32'd1000, 32'd7, 1'b1);
  endtask

  task automatic test_reset_abort;
    int dc, bc;
    @(negedge clk);
    start = 1'b1; op = 2'b10; A = 32'd123456; B = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_abort: got HI=%h LO=%h busy=%b done=%b expected all zero", HI, LO, busy, done);
    end
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    dc = 0; bc = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dc++;
      if (busy) bc++;
      @(negedge clk);
    end
    checks++;
    if (dc != 0 || bc != 0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL reset_no_done: got done=%0d busy=%0d HI=%h LO=%h expected 0 0 0 0", dc, bc, HI, LO);
    end
    run_op("multu_after_reset", 2'b00, 32'd3, 32'd5, 1'b0);
  endtask

  task automatic test_mt_write;
    int dc, bc;
    @(negedge clk);
    mthi = 1'b1; start = 1'b1; op = 2'b00; A = 32'h1234_5678; B = 32'd9;
    @(negedge clk);
    mthi = 1'b0; start = 1'b0;
    m_hi = 32'h1234_5678;
    dc = 0; bc = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dc++;
      if (busy) bc++;
      @(negedge clk);
    end
    checks++;
    if (HI !== m_hi || LO !== m_lo) begin
      errors++; $display("FAIL mthi_prio: got HI=%h LO=%h expected %h %h", HI, LO, m_hi, m_lo);
    end
    checks++;
    if (dc != 0 || bc != 0) begin
      errors++; $display("FAIL mthi_prio_idle: got done=%0d busy=%0d expected 0 0", dc, bc);
    end
    mthi = 1'b1; mtlo = 1'b1; A = $urandom;
    m_hi = A; m_lo = A;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; A = $urandom;
    m_lo = A;
    @(negedge clk);
    mtlo = 1'b0; A = $urandom;
    @(negedge clk);
    checks++;
    if (HI !== m_hi || LO !== m_lo) begin
      errors++; $display("FAIL mt_both: got HI=%h LO=%h expected %h %h", HI, LO, m_hi, m_lo);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; A = 32'd0; B = 32'd0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_directed();
    test_back_to_back();
    test_mt_write();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
